// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the SPI master controller: FSM state
//            encoding and default frame/clock-divider constants.
// Contents : spi_state_t  - controller state enum (IDLE, SETUP, XFER, HOLD)
//            SPI_DATA_W   - default frame length in bits
//            SPI_CLK_DIV  - default SCLK half-period in i_clk cycles
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_gen
// Purpose  : SCLK generator. Divides i_clk by CLK_DIV per half-period and
//            emits one-cycle rise/fall strobes aligned with the edge on
//            which the registered SCLK level changes.
// Ports    : i_clk    - system clock, rising edge
//            i_rst    - asynchronous active-low reset
//            i_en     - run the divider (controller is in XFER)
//            i_launch - produce the first rising edge of the frame now
//            o_sclk   - registered serial clock level, idle low
//            o_rise   - SCLK rises at the coming i_clk edge
//            o_fall   - SCLK falls at the coming i_clk edge
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_launch,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int                 c_CNT_W   = $clog2(CLK_DIV) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(CLK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sclk;
  logic               w_tc;

  // Terminal count of the half-period counter while running.
  assign w_tc   = i_en && (r_cnt == c_CNT_TOP);

  // The first rising edge is requested by the controller (end of SETUP);
  // all later edges come from the divider itself.
  assign o_rise = i_launch || (w_tc && !r_sclk);
  assign o_fall = w_tc && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (i_launch) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_en) begin
      if (w_tc) begin
        r_cnt  <= '0;
        r_sclk <= !r_sclk;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end else begin
      // Outside XFER the divider is parked with SCLK low.
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end
  end

endmodule : spi_clk_gen
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : Single-frame SPI master (mode 0: SCLK idle low, sample on the
//            rising edge, shift on the falling edge), MSB first, full duplex.
//            Frame: SETUP (CLK_DIV cycles, CS low, first bit on MOSI),
//            XFER (DATA_W SCLK periods), HOLD (CLK_DIV cycles), then CS high
//            with a one-cycle done pulse and the received word on o_data.
// Ports    : i_clk   - system clock, rising edge
//            i_rst   - asynchronous active-low reset
//            i_start - transfer request, honoured only in IDLE
//            i_data  - transmit word, latched at start
//            o_busy  - frame in progress
//            o_done  - one-cycle end-of-frame pulse
//            o_data  - last complete received word
//            o_sclk  - serial clock, idle low
//            o_mosi  - serial data out
//            i_miso  - serial data in
//            o_cs    - chip select, active low
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs
);

  localparam int                 c_CNT_W    = $clog2(CLK_DIV) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_TOP  = c_CNT_W'(CLK_DIV - 1);
  localparam int                 c_BIT_W    = $clog2(DATA_W);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);

  spi_state_t          r_state;
  logic [c_CNT_W-1:0]  r_cnt;      // SETUP / HOLD duration counter
  logic [c_BIT_W-1:0]  r_bit;      // falling edges seen in this frame
  logic [DATA_W-1:0]   r_tx;       // transmit shifter, MSB is on o_mosi
  logic [DATA_W-1:0]   r_rx;       // receive shifter
  logic [DATA_W-1:0]   r_data;
  logic                r_cs;
  logic                r_busy;
  logic                r_done;
  logic                r_mosi;

  logic                w_launch;
  logic                w_xfer;
  logic                w_rise;
  logic                w_fall;
  logic                w_sclk;

  // Last cycle of SETUP: the first SCLK rising edge happens on this edge.
  assign w_launch = (r_state == SETUP) && (r_cnt == c_CNT_TOP);
  assign w_xfer   = (r_state == XFER);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_xfer),
    .i_launch (w_launch),
    .o_sclk   (w_sclk),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_data  <= '0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // MISO is captured on every SCLK rising edge, including the launch
      // edge that closes SETUP.
      if (w_rise) begin
        r_rx <= {r_rx[DATA_W-2:0], i_miso};
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (i_start) begin
            r_tx    <= i_data;
            r_rx    <= '0;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_mosi  <= i_data[DATA_W-1];
            r_state <= SETUP;
          end
        end

        SETUP: begin
          if (r_cnt == c_CNT_TOP) begin
            r_cnt   <= '0;
            r_state <= XFER;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end

        XFER: begin
          if (w_fall) begin
            if (r_bit == c_BIT_LAST) begin
              // Last falling edge: MOSI keeps the final bit through HOLD.
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_bit  <= r_bit + 1'b1;
              r_mosi <= r_tx[DATA_W-2];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
          end
        end

        HOLD: begin
          if (r_cnt == c_CNT_TOP) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_mosi  <= 1'b0;
            r_data  <= r_rx;
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_data = r_data;
  assign o_sclk = w_sclk;
  assign o_mosi = r_mosi;
  assign o_cs   = r_cs;

endmodule : spi_master_ctrl
`default_nettype wire
